apb_master: RTL
===============

Name: apb_master

Overview:
- APB requester that drives the peripheral bus on behalf of a simple local command port.
- Accepts one read or write command at a time and sequences the APB SETUP and ACCESS phases.
- Waits for p_ready, then returns read data and completion status on a one-cycle response strobe.
- Sits between the test/control logic and any APB completer on the same p_clk domain.

Parameters:
- A_WIDTH, 8, address width in bits.
- D_WIDTH, 8, data width in bits.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait in cycles; used only when APB_TIMEOUT_EN is defined; legal range is 1 to 2^16-1.

Ports:
- p_clk  in  1  clock; all logic is on the rising edge.
- p_rstn  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when the block can accept a command (state IDLE).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  A_WIDTH  command address.
- cmd_wdata  in  D_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  D_WIDTH  read data for the completed transfer.
- rsp_err  out  1  transfer aborted by timeout; valid only with rsp_valid.
- p_sel  out  1  APB select.
- p_enable  out  1  APB enable.
- p_write  out  1  APB direction.
- p_addr  out  A_WIDTH  APB address.
- wr_data  out  D_WIDTH  APB write data.
- rd_data  in  D_WIDTH  APB read data.
- p_ready  in  1  completer ready.

Behaviour:
- Clock and reset: one clock, p_clk. Reset p_rstn is synchronous and active-low.
- Reset values: state = IDLE; p_sel, p_enable, p_write, rsp_valid and rsp_err = 0; p_addr, wr_data and rsp_rdata = 0.
- All APB outputs and all rsp_* outputs are registered. cmd_ready is decoded from the state register only (state == IDLE).
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid at the clock edge: latch write/addr/wdata into p_write/p_addr/wr_data, set p_sel = 1, go to SETUP.
- SETUP: lasts exactly one cycle with p_sel = 1 and p_enable = 0. Next state is ACCESS, with p_enable set to 1.
- ACCESS:
  - p_sel = 1 and p_enable = 1; p_addr, p_write and wr_data are held stable.
  - When p_ready is sampled high: clear p_sel and p_enable, go to IDLE.
  - In the same edge, set rsp_valid = 1 for exactly one cycle.
  - For a read, rsp_rdata is loaded with rd_data. For a write, rsp_rdata keeps its previous value. rsp_err = 0.
  - While p_ready is low: remain in ACCESS with all outputs unchanged.
- Latency (zero-wait completer):
  - Command accepted at edge N.
  - SETUP in cycle N+1, ACCESS in cycle N+2.
  - rsp_valid high in cycle N+3, which is also IDLE with cmd_ready = 1.
  - Minimum spacing is 3 cycles per transfer. Each additional low p_ready cycle adds 1.
- cmd_valid while cmd_ready = 0 is ignored and no state is captured. The command source must hold cmd_valid until it sees cmd_ready.
- Reset mid-transfer: the in-flight command is dropped and no rsp_valid is produced. All outputs return to their reset values on the next edge.
- p_ready is ignored outside ACCESS. rd_data is sampled only on a read completion.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments every ACCESS cycle with p_ready low.
  - When the counter reaches TIMEOUT_CYCLES, the transfer is aborted: p_sel and p_enable are cleared, state goes to IDLE.
  - rsp_valid is pulsed with rsp_err = 1 and rsp_rdata = 0.
  - If p_ready arrives in the same cycle the limit is reached, normal completion wins.
- Undefined: ACCESS waits indefinitely, rsp_err is tied to 0, and no counter logic is present.

Decomposition:
- Package apb_pkg:
  - typedef enum logic [1:0] apb_state_t {IDLE = 0, SETUP = 1, ACCESS = 2}.
  - Default width constants A_WIDTH_DEF = 8 and D_WIDTH_DEF = 8.
- One sub-module, apb_wait_timer:
  - Parameter-width saturating counter with clear/enable inputs and an expired output.
  - Instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Reset: hold p_rstn = 0 for 2 cycles, then release. Require all outputs at reset values and cmd_ready = 1.
- Write, zero wait:
  - Stimulus: cmd_write = 1, addr = 0x05, wdata = 0xA5, completer p_ready = 1.
  - Require: p_sel in cycles N+1 and N+2, p_enable only in N+2, p_addr = 0x05, wr_data = 0xA5, rsp_valid pulse in N+3, rsp_err = 0.
- Read with 3 wait states:
  - Stimulus: addr = 0x05, p_ready low for 3 ACCESS cycles, rd_data = 0xA5 on the ready cycle.
  - Require: rsp_valid in cycle N+6, rsp_rdata = 0xA5, p_addr stable throughout.
- Back-to-back: cmd_valid held high with two commands queued. Require the second SETUP to start exactly 3 cycles after the first, with no overlap of p_sel.
- Reset mid-ACCESS: assert p_rstn = 0 while p_ready is low. Require p_sel = p_enable = 0 on the next edge and no rsp_valid.
- Timeout (APB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4): hold p_ready low. Require the abort after 4 ACCESS cycles with rsp_err = 1, rsp_rdata = 0 and cmd_ready = 1.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default widths for the APB requester.
// Provides the FSM state enum, width defaults and the wait-timer width.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int A_WIDTH_DEF = 8;
    localparam int D_WIDTH_DEF = 8;

    // Timeout limit is at most 2^16-1, so 16 bits always hold it.
    localparam int TMO_W = 16;

endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: local command/response port plus APB bus signals.
// master modport is the requester view; slave is the environment view.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_write;
    logic [A_WIDTH-1:0] cmd_addr;
    logic [D_WIDTH-1:0] cmd_wdata;

    logic               rsp_valid;
    logic [D_WIDTH-1:0] rsp_rdata;
    logic               rsp_err;

    logic               p_sel;
    logic               p_enable;
    logic               p_write;
    logic [A_WIDTH-1:0] p_addr;
    logic [D_WIDTH-1:0] wr_data;
    logic [D_WIDTH-1:0] rd_data;
    logic               p_ready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rd_data, p_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output p_sel, p_enable, p_write, p_addr, wr_data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rd_data, p_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  p_sel, p_enable, p_write, p_addr, wr_data
    );

endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating ACCESS-phase wait counter.
// Ports: clk, rst_n (sync, active-low), clr, en in; expired out.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int W     = TMO_W,
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] MAX  = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // High on the wait cycle whose edge brings the count to LIMIT.
    assign expired = en && (cnt_q >= LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master.sv
// apb_master: APB requester sequencing SETUP/ACCESS for one local command.
// Ports: p_clk, p_rstn (sync, active-low), bus (apb_master_if.master).
// Optional macro APB_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES waits.
module apb_master
    import apb_pkg::*;
#(
    parameter int A_WIDTH        = A_WIDTH_DEF,
    parameter int D_WIDTH        = D_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            p_clk,
    input  logic            p_rstn,
    apb_master_if.master    bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
        $error("apb_master: TIMEOUT_CYCLES out of range");
    end

    apb_state_t         state_q, state_d;
    logic               p_sel_q, p_sel_d;
    logic               p_enable_q, p_enable_d;
    logic               p_write_q, p_write_d;
    logic [A_WIDTH-1:0] p_addr_q, p_addr_d;
    logic [D_WIDTH-1:0] wr_data_q, wr_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [D_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;
    logic tmo_expired;

    // Cleared during SETUP so every ACCESS starts from zero.
    apb_wait_timer #(
        .W     (TMO_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (p_clk),
        .rst_n   (p_rstn),
        .clr     (state_q == SETUP),
        .en      (state_q == ACCESS && !bus.p_ready),
        .expired (tmo_expired)
    );
`endif

    always_comb begin
        state_d     = state_q;
        p_sel_d     = p_sel_q;
        p_enable_d  = p_enable_q;
        p_write_d   = p_write_q;
        p_addr_d    = p_addr_q;
        wr_data_d   = wr_data_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
        rsp_err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    p_write_d = bus.cmd_write;
                    p_addr_d  = bus.cmd_addr;
                    wr_data_d = bus.cmd_wdata;
                    p_sel_d   = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                p_enable_d = 1'b1;
                state_d    = ACCESS;
            end
            ACCESS: begin
                // Ready has priority over a timeout on the same cycle.
                if (bus.p_ready) begin
                    p_sel_d     = 1'b0;
                    p_enable_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (!p_write_q) begin
                        rsp_rdata_d = bus.rd_data;
                    end
                    state_d     = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_expired) begin
                    p_sel_d     = 1'b0;
                    p_enable_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end
`endif
            end
            default: begin
                p_sel_d    = 1'b0;
                p_enable_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (!p_rstn) begin
            state_q     <= IDLE;
            p_sel_q     <= 1'b0;
            p_enable_q  <= 1'b0;
            p_write_q   <= 1'b0;
            p_addr_q    <= '0;
            wr_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            p_sel_q     <= p_sel_d;
            p_enable_q  <= p_enable_d;
            p_write_q   <= p_write_d;
            p_addr_q    <= p_addr_d;
            wr_data_q   <= wr_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge p_clk) begin
        if (!p_rstn) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.p_sel     = p_sel_q;
    assign bus.p_enable  = p_enable_q;
    assign bus.p_write   = p_write_q;
    assign bus.p_addr    = p_addr_q;
    assign bus.wr_data   = wr_data_q;

endmodule
